// File: rtl/y86_fetch_pipe.sv
// Y86-64 PIPE fetch stage: F register, byte-addressed imem, instruction split/validate,
// next-PC prediction and F/D pipeline register. Optional macro FETCH_BTFN_EN enables BTFN jXX prediction.
module y86_fetch_pipe #(
  parameter int unsigned IMEM_BYTES  = 1024,
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter bit          HALT_STICKY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        bubble_d,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        imem_we,
  input  logic [63:0] imem_waddr,
  input  logic [7:0]  imem_wdata,
  output logic [63:0] f_pc,
  output logic        d_bubble,
  output logic [2:0]  d_stat,
  output logic [3:0]  d_icode,
  output logic [3:0]  d_ifun,
  output logic [3:0]  d_ra,
  output logic [3:0]  d_rb,
  output logic [63:0] d_valc,
  output logic [63:0] d_valp,
  output logic [63:0] d_altpc,
  output logic        halted
);

  localparam int          AW       = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [64:0] IMEM_LIM = 65'(IMEM_BYTES);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  logic [7:0]  imem [IMEM_BYTES];
  logic [7:0]  ibyte [10];
  logic [64:0] raddr [10];

  logic [3:0]  icode_raw, ifun_raw, icode_f, ifun_f, ra_f, rb_f, len;
  logic [63:0] valc_f, valp_f, pred_pc, alt_pc;
  logic [64:0] end_addr;
  logic        need_regs, ifun_ok, imem_error, instr_invalid;
  logic [2:0]  stat_f;

  always_ff @(posedge clk) begin
    if (imem_we && ({1'b0, imem_waddr} < IMEM_LIM))
      imem[imem_waddr[AW-1:0]] <= imem_wdata;
  end

  // Bytes past the end of memory read as zero; imem_error flags them anyway.
  always_comb begin
    for (int i = 0; i < 10; i++) begin
      raddr[i] = {1'b0, f_pc} + 65'(i);
      ibyte[i] = (raddr[i] < IMEM_LIM) ? imem[raddr[i][AW-1:0]] : 8'h00;
    end
  end

  always_comb begin
    icode_raw = ibyte[0][7:4];
    ifun_raw  = ibyte[0][3:0];
    need_regs = 1'b0;
    len       = 4'd1;
    valc_f    = 64'h0;
    case (icode_raw)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        need_regs = 1'b1;
        len       = 4'd2;
      end
      4'h3, 4'h4, 4'h5: begin
        need_regs = 1'b1;
        len       = 4'd10;
        valc_f    = {ibyte[9], ibyte[8], ibyte[7], ibyte[6],
                     ibyte[5], ibyte[4], ibyte[3], ibyte[2]};
      end
      4'h7, 4'h8: begin
        len    = 4'd9;
        valc_f = {ibyte[8], ibyte[7], ibyte[6], ibyte[5],
                  ibyte[4], ibyte[3], ibyte[2], ibyte[1]};
      end
      default: ;
    endcase
    ra_f = need_regs ? ibyte[1][7:4] : 4'hF;
    rb_f = need_regs ? ibyte[1][3:0] : 4'hF;

    case (icode_raw)
      I_OPQ:           ifun_ok = (ifun_raw <= 4'd3);
      I_RRMOVQ, I_JXX: ifun_ok = (ifun_raw <= 4'd6);
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                       ifun_ok = (ifun_raw == 4'd0);
      default:         ifun_ok = 1'b0;
    endcase
    instr_invalid = !ifun_ok;

    // 65-bit end address so a PC near 2^64 cannot wrap into a legal range.
    end_addr   = {1'b0, f_pc} + 65'(len) - 65'd1;
    imem_error = (end_addr >= IMEM_LIM);
    valp_f     = f_pc + 64'(len);
    icode_f    = imem_error ? I_NOP : icode_raw;
    ifun_f     = imem_error ? 4'h0  : ifun_raw;

    if (imem_error)              stat_f = STAT_ADR;
    else if (instr_invalid)      stat_f = STAT_INS;
    else if (icode_raw == I_HALT) stat_f = STAT_HLT;
    else                         stat_f = STAT_AOK;
  end

  always_comb begin
    pred_pc = valp_f;
    alt_pc  = valp_f;
    if (icode_f == I_CALL || icode_f == I_JXX) begin
`ifdef FETCH_BTFN_EN
      // Conditional forward branches are predicted not taken.
      if (icode_f == I_JXX && ifun_f != 4'h0 && valc_f >= f_pc) begin
        pred_pc = valp_f;
        alt_pc  = valc_f;
      end else begin
        pred_pc = valc_f;
        alt_pc  = valp_f;
      end
`else
      pred_pc = valc_f;
      alt_pc  = valp_f;
`endif
    end
  end

  // Control inputs are level-sampled at each rising edge with priority
  // redirect > stall_f/halted > advance for F, and stall_d > bubble_d/halted > load for D.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pc   <= RESET_PC;
      halted <= 1'b0;
    end else if (redirect_valid) begin
      f_pc   <= redirect_pc;
      halted <= 1'b0;
    end else if (!(stall_f || halted)) begin
      f_pc <= pred_pc;
      if (HALT_STICKY && stat_f != STAT_AOK)
        halted <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_bubble <= 1'b1;
      d_stat   <= STAT_AOK;
      d_icode  <= I_NOP;
      d_ifun   <= 4'h0;
      d_ra     <= 4'h0;
      d_rb     <= 4'h0;
      d_valc   <= 64'h0;
      d_valp   <= 64'h0;
      d_altpc  <= 64'h0;
    end else if (stall_d) begin
      d_bubble <= d_bubble;
    end else if (bubble_d || halted) begin
      d_bubble <= 1'b1;
      d_stat   <= STAT_AOK;
      d_icode  <= I_NOP;
      d_ifun   <= 4'h0;
      d_ra     <= 4'h0;
      d_rb     <= 4'h0;
      d_valc   <= 64'h0;
      d_valp   <= 64'h0;
      d_altpc  <= 64'h0;
    end else begin
      d_bubble <= 1'b0;
      d_stat   <= stat_f;
      d_icode  <= icode_f;
      d_ifun   <= ifun_f;
      d_ra     <= ra_f;
      d_rb     <= rb_f;
      d_valc   <= valc_f;
      d_valp   <= valp_f;
      d_altpc  <= alt_pc;
    end
  end

endmodule

// File: tb/tb_y86_fetch_pipe.sv
// Directed bench for y86_fetch_pipe: program load, split, prediction, stall/bubble,
// halt/error freeze, boundary fetches, async reset and jXX prediction (FETCH_BTFN_EN aware).
module tb_y86_fetch_pipe;

  logic        clk, rst_n;
  logic        stall_f, stall_d, bubble_d, redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [7:0]  imem_wdata;
  logic [63:0] f_pc, d_valc, d_valp, d_altpc;
  logic        d_bubble, halted;
  logic [2:0]  d_stat;
  logic [3:0]  d_icode, d_ifun, d_ra, d_rb;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];

  y86_fetch_pipe dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f), .stall_d(stall_d), .bubble_d(bubble_d),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .f_pc(f_pc), .d_bubble(d_bubble), .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_ra(d_ra), .d_rb(d_rb), .d_valc(d_valc), .d_valp(d_valp), .d_altpc(d_altpc),
    .halted(halted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [63:0] a, input logic [7:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    step();
    imem_we = 1'b0;
  endtask

  task automatic wr64(input logic [63:0] a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) wr(a + 64'(i), v[8*i +: 8]);
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic load_program();
    wr(0, 8'h30);    wr(1, 8'hF2);    wr64(2, 64'd10);      // irmovq $10,%rdx (byte 5 = halt)
    wr(10, 8'h80);   wr64(11, 64'h40);                      // call 0x40
    wr(19, 8'h60);   wr(20, 8'h23);                         // addq %rdx,%rbx
    wr(21, 8'h10);   wr(22, 8'h10);   wr(23, 8'h00);        // nop nop halt
    wr(64'h20, 8'h74); wr64(64'h21, 64'h10);                // jne 0x10 (backward)
    wr(64'h30, 8'h74); wr64(64'h31, 64'h80);                // jne 0x80 (forward)
    wr(64'h40, 8'h10);
    wr(64'h60, 8'hC0);
    wr(64'h70, 8'h27);
    wr(1014, 8'h30); wr(1015, 8'hF0); wr64(1016, 64'h0000_0030_0000_0000); // also 0x30 at 1020
    wr(1024, 8'hFF);                                        // out of range: must be dropped
    wr(64'h8000_0000_0000_0000, 8'hFF);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_f = 0; stall_d = 0; bubble_d = 0; redirect_valid = 0;
    redirect_pc = 0; imem_we = 0; imem_waddr = 0; imem_wdata = 0;
    load_program();
    n_total++; if (f_pc !== 64'h0) $display("FAIL reset_fpc got %h exp %h", f_pc, 64'h0); else n_pass++;
    n_total++; if (d_bubble !== 1'b1) $display("FAIL reset_bubble got %b exp 1", d_bubble); else n_pass++;
    n_total++; if (d_stat !== 3'd1) $display("FAIL reset_stat got %0d exp 1", d_stat); else n_pass++;
    n_total++; if (d_icode !== 4'h1) $display("FAIL reset_icode got %h exp 1", d_icode); else n_pass++;
    n_total++; if (d_valc !== 64'h0 || d_valp !== 64'h0 || d_altpc !== 64'h0 || d_ra !== 4'h0)
      $display("FAIL reset_fields got valc=%h valp=%h alt=%h ra=%h exp 0", d_valc, d_valp, d_altpc, d_ra); else n_pass++;
    n_total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", halted); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_irmovq();
    step();
    n_total++; if (d_icode !== 4'h3 || d_ifun !== 4'h0) $display("FAIL irmov_icode got %h/%h exp 3/0", d_icode, d_ifun); else n_pass++;
    n_total++; if (d_ra !== 4'hF || d_rb !== 4'h2) $display("FAIL irmov_regs got %h/%h exp F/2", d_ra, d_rb); else n_pass++;
    n_total++; if (d_valc !== 64'd10) $display("FAIL irmov_valc got %h exp %h", d_valc, 64'd10); else n_pass++;
    n_total++; if (d_valp !== 64'd10) $display("FAIL irmov_valp got %h exp %h", d_valp, 64'd10); else n_pass++;
    n_total++; if (d_stat !== 3'd1 || d_bubble !== 1'b0) $display("FAIL irmov_stat got %0d/%b exp 1/0", d_stat, d_bubble); else n_pass++;
    n_total++; if (f_pc !== 64'd10) $display("FAIL irmov_fpc got %h exp %h", f_pc, 64'd10); else n_pass++;
  endtask

  task automatic test_call_redirect();
    step();
    n_total++; if (d_icode !== 4'h8) $display("FAIL call_icode got %h exp 8", d_icode); else n_pass++;
    n_total++; if (d_valc !== 64'h40) $display("FAIL call_valc got %h exp 40", d_valc); else n_pass++;
    n_total++; if (d_valp !== 64'd19 || d_altpc !== 64'd19) $display("FAIL call_valp got %h/%h exp 13/13", d_valp, d_altpc); else n_pass++;
    n_total++; if (f_pc !== 64'h40) $display("FAIL call_fpc got %h exp 40", f_pc); else n_pass++;
    redirect(64'd19);
    n_total++; if (f_pc !== 64'd19) $display("FAIL redir_fpc got %h exp 13", f_pc); else n_pass++;
    n_total++; if (d_icode !== 4'h1 || d_valp !== 64'h41) $display("FAIL redir_d got %h/%h exp 1/41", d_icode, d_valp); else n_pass++;
  endtask

  task automatic test_stall_bubble();
    step();
    n_total++; if (d_icode !== 4'h6 || d_ra !== 4'h2 || d_rb !== 4'h3 || d_valp !== 64'd21)
      $display("FAIL addq_d got %h %h %h %h exp 6 2 3 15", d_icode, d_ra, d_rb, d_valp); else n_pass++;
    stall_f = 1'b1; stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++; if (f_pc !== 64'd21 || d_icode !== 4'h6 || d_valp !== 64'd21 || d_ra !== 4'h2 || d_bubble !== 1'b0)
        $display("FAIL stall_hold got pc=%h ic=%h valp=%h ra=%h bub=%b exp 15 6 15 2 0", f_pc, d_icode, d_valp, d_ra, d_bubble); else n_pass++;
    end
    stall_f = 1'b0; stall_d = 1'b0; bubble_d = 1'b1;
    step();
    bubble_d = 1'b0;
    n_total++; if (d_bubble !== 1'b1 || d_icode !== 4'h1 || d_valp !== 64'h0)
      $display("FAIL bubble_d got bub=%b ic=%h valp=%h exp 1 1 0", d_bubble, d_icode, d_valp); else n_pass++;
    n_total++; if (f_pc !== 64'd22) $display("FAIL bubble_fpc got %h exp 16", f_pc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(64'd23);
    exp_q.push_back(64'd24);
    for (int i = 0; i < 2; i++) begin
      logic [63:0] e;
      step();
      e = exp_q.pop_front();
      n_total++; if (d_valp !== e || d_bubble !== 1'b0) $display("FAIL b2b_valp got %h exp %h", d_valp, e); else n_pass++;
    end
    n_total++; if (d_stat !== 3'd2 || d_icode !== 4'h0 || halted !== 1'b1)
      $display("FAIL b2b_halt got stat=%0d ic=%h halted=%b exp 2 0 1", d_stat, d_icode, halted); else n_pass++;
    step();
    n_total++; if (d_bubble !== 1'b1 || f_pc !== 64'd24) $display("FAIL b2b_frozen got bub=%b pc=%h exp 1 18", d_bubble, f_pc); else n_pass++;
  endtask

  task automatic test_halt();
    redirect(64'd5);
    n_total++; if (halted !== 1'b0 || f_pc !== 64'd5 || d_bubble !== 1'b1)
      $display("FAIL halt_redir got halted=%b pc=%h bub=%b exp 0 5 1", halted, f_pc, d_bubble); else n_pass++;
    step();
    n_total++; if (d_stat !== 3'd2 || halted !== 1'b1 || d_valp !== 64'd6)
      $display("FAIL halt_fetch got stat=%0d halted=%b valp=%h exp 2 1 6", d_stat, halted, d_valp); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step();
      n_total++; if (d_bubble !== 1'b1 || f_pc !== 64'd6 || halted !== 1'b1)
        $display("FAIL halt_frozen got bub=%b pc=%h halted=%b exp 1 6 1", d_bubble, f_pc, halted); else n_pass++;
    end
    redirect(64'd0);
    n_total++; if (halted !== 1'b0 || f_pc !== 64'd0) $display("FAIL halt_clear got halted=%b pc=%h exp 0 0", halted, f_pc); else n_pass++;
  endtask

  task automatic test_invalid();
    redirect(64'h60);
    step();
    n_total++; if (d_stat !== 3'd4 || d_icode !== 4'hC || halted !== 1'b1)
      $display("FAIL ins_icode got stat=%0d ic=%h halted=%b exp 4 C 1", d_stat, d_icode, halted); else n_pass++;
    redirect(64'h70);
    step();
    n_total++; if (d_stat !== 3'd4 || d_icode !== 4'h2 || d_ifun !== 4'h7)
      $display("FAIL ins_ifun got stat=%0d ic=%h fn=%h exp 4 2 7", d_stat, d_icode, d_ifun); else n_pass++;
  endtask

  task automatic test_boundary();
    redirect(64'd1014);
    step();
    n_total++; if (d_stat !== 3'd1 || d_icode !== 4'h3 || d_valc !== 64'h0000_0030_0000_0000 || d_valp !== 64'd1024)
      $display("FAIL edge_ok got stat=%0d ic=%h valc=%h valp=%h exp 1 3 3000000000 400", d_stat, d_icode, d_valc, d_valp); else n_pass++;
    n_total++; if (halted !== 1'b0 || f_pc !== 64'd1024) $display("FAIL edge_ok_pc got halted=%b pc=%h exp 0 400", halted, f_pc); else n_pass++;
    step();
    n_total++; if (d_stat !== 3'd3 || d_icode !== 4'h1 || halted !== 1'b1)
      $display("FAIL edge_past got stat=%0d ic=%h halted=%b exp 3 1 1", d_stat, d_icode, halted); else n_pass++;
    redirect(64'd1020);
    step();
    n_total++; if (d_stat !== 3'd3 || d_icode !== 4'h1 || d_ifun !== 4'h0)
      $display("FAIL edge_adr got stat=%0d ic=%h fn=%h exp 3 1 0", d_stat, d_icode, d_ifun); else n_pass++;
  endtask

  task automatic test_btfn();
    logic [63:0] exp_pc, exp_alt;
    redirect(64'h20);
    step();
    n_total++; if (f_pc !== 64'h10) $display("FAIL jback_fpc got %h exp 10", f_pc); else n_pass++;
    n_total++; if (d_icode !== 4'h7 || d_ifun !== 4'h4 || d_valc !== 64'h10 || d_valp !== 64'h29 || d_altpc !== 64'h29)
      $display("FAIL jback_d got %h %h %h %h %h exp 7 4 10 29 29", d_icode, d_ifun, d_valc, d_valp, d_altpc); else n_pass++;
`ifdef FETCH_BTFN_EN
    exp_pc = 64'h39; exp_alt = 64'h80;
`else
    exp_pc = 64'h80; exp_alt = 64'h39;
`endif
    redirect(64'h30);
    step();
    n_total++; if (f_pc !== exp_pc) $display("FAIL jfwd_fpc got %h exp %h", f_pc, exp_pc); else n_pass++;
    n_total++; if (d_altpc !== exp_alt || d_valc !== 64'h80 || d_valp !== 64'h39)
      $display("FAIL jfwd_d got alt=%h valc=%h valp=%h exp %h 80 39", d_altpc, d_valc, d_valp, exp_alt); else n_pass++;
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (f_pc !== 64'h0 || d_bubble !== 1'b1 || d_icode !== 4'h1 || halted !== 1'b0)
      $display("FAIL async_rst got pc=%h bub=%b ic=%h halted=%b exp 0 1 1 0", f_pc, d_bubble, d_icode, halted); else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++; if (d_icode !== 4'h3 || d_valc !== 64'd10 || f_pc !== 64'd10)
      $display("FAIL post_rst got ic=%h valc=%h pc=%h exp 3 a a", d_icode, d_valc, f_pc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_irmovq();
    test_call_redirect();
    test_stall_bubble();
    test_back_to_back();
    test_halt();
    test_invalid();
    test_boundary();
    test_btfn();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/y86_fetch_pipe.md
Name: y86_fetch_pipe

Overview:
- Pipelined fetch stage for the Y86-64 PIPE processor. It replaces the single-cycle SEQ fetch used so far.
- Holds the F register (predicted PC) and an internal byte-addressed instruction memory of parametrised depth.
- Splits and validates each instruction and predicts the next PC.
- Drives the F/D pipeline register under stall/bubble/redirect control from the hazard unit.
- A halt/error fetch freezes the stage until a redirect or reset.

Parameters:
- IMEM_BYTES, 1024, instruction memory size in bytes; legal addresses 0..IMEM_BYTES-1.
- RESET_PC, 64'h0, value loaded into the F register on reset.
- HALT_STICKY, 1, when 1 the stage freezes after fetching halt or an error instruction; when 0 it keeps fetching.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_f  in  1  hold the F register.
- stall_d  in  1  hold the D register.
- bubble_d  in  1  load a bubble into the D register.
- redirect_valid  in  1  mispredict or ret correction is present.
- redirect_pc  in  64  corrected PC.
- imem_we  in  1  program-load write strobe.
- imem_waddr  in  64  program-load byte address.
- imem_wdata  in  8  program-load byte.
- f_pc  out  64  current fetch PC (F register).
- d_bubble  out  1  D register holds a bubble.
- d_stat  out  3  1 = AOK, 2 = HLT, 3 = ADR, 4 = INS.
- d_icode  out  4  registered icode.
- d_ifun  out  4  registered ifun.
- d_ra  out  4  registered rA.
- d_rb  out  4  registered rB.
- d_valc  out  64  registered valC.
- d_valp  out  64  registered valP.
- d_altpc  out  64  PC not chosen by the prediction (the recovery target).
- halted  out  1  fetch is frozen.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - f_pc = RESET_PC, halted = 0.
  - D register = bubble: d_bubble = 1, d_stat = 1, d_icode = 4'h1, every other D field 0.
  - imem contents are not reset.
- imem write: a byte is written on the rising edge when imem_we = 1 and imem_waddr < IMEM_BYTES; writes outside that range are ignored. Reads are combinational from f_pc.
- Split (combinational from f_pc):
  - byte0 gives icode = [7:4], ifun = [3:0].
  - Opcodes that need a register byte (2,3,4,5,6,A,B) take rA/rB from byte1; otherwise rA = rB = 4'hF.
  - valC is 8 bytes little-endian. It sits at offset 2 for icode 3/4/5 and at offset 1 for icode 7/8; otherwise valC = 0.
  - Instruction length and valP = f_pc + length:
    - length 1: icode 0, 1, 9.
    - length 2: icode 2, 6, A, B.
    - length 9: icode 7, 8.
    - length 10: icode 3, 4, 5.
- Error checks:
  - imem_error: f_pc + length - 1 >= IMEM_BYTES. Compute with 65-bit arithmetic so a wrap past 2^64 counts as an error.
  - instr_invalid: icode > 4'hB, OR ifun out of range. Allowed ifun is 0..3 for icode 6, 0..6 for icode 2/7, and 0 only for all other icodes.
  - When imem_error = 1, icode/ifun are forced to 1/0, so the D register carries a nop.
- Status, in priority order: ADR if imem_error; else INS if instr_invalid; else HLT if icode = 0; else AOK.
- Prediction:
  - icode 7 or 8: pred = valC, alt = valP.
  - All other icodes: pred = valP, alt = valP.
- F register update at each edge, in priority order:
  1. redirect_valid: f_pc <= redirect_pc, halted <= 0. This overrides stall_f and halted.
  2. stall_f or halted: hold.
  3. Otherwise: f_pc <= pred. If HALT_STICKY = 1 and the status is not AOK, also set halted <= 1.
- D register update at each edge, in priority order:
  1. stall_d: hold. stall_d wins over bubble_d.
  2. bubble_d, or halted = 1 at the edge: load a bubble.
  3. Otherwise: load the split fields, status, valP and alt, with d_bubble = 0.
- Latency: an instruction at f_pc appears on the D outputs one edge later. A redirect presented in cycle N is fetched in cycle N+1.

Optional Feature:
- Macro FETCH_BTFN_EN.
- Defined: jXX with ifun != 0 is predicted taken only when valC < f_pc (backward branch). Forward branches get pred = valP, alt = valC. Unconditional jmp (ifun 0) and call always take valC.
- Undefined: jXX is always predicted taken, as described under Prediction.

Test Plan:
- irmovq at 0: load 30 F2 0A 00 00 00 00 00 00 00, release reset -> after 1 edge: d_icode = 3, d_ra = F, d_rb = 2, d_valc = 10, d_valp = 10, d_stat = 1, f_pc = 10.
- call at 10: load 80 40 00.. -> d_valc = 0x40, d_valp = 19, d_altpc = 19, f_pc = 0x40. Then redirect_valid with redirect_pc = 19 -> f_pc = 19 on the next edge.
- Stall/bubble: hold stall_f = 1 and stall_d = 1 for 3 cycles -> f_pc and all D outputs are unchanged. Then bubble_d = 1 -> d_bubble = 1, d_icode = 1.
- Halt and errors:
  - Halt byte 00 at address 5 -> d_stat = 2, halted = 1; following cycles give bubbles with f_pc held; redirect_pc = 0 clears halted.
  - Byte 0xC0 -> d_stat = 4.
  - irmovq at IMEM_BYTES - 4 -> d_stat = 3.
- Asynchronous reset mid-run: drop rst_n between edges -> f_pc = RESET_PC and d_bubble = 1 immediately, without waiting for a clock edge.
- FETCH_BTFN_EN: jne (74) at 0x20 with target 0x10 -> f_pc = 0x10. With target 0x80 -> f_pc = 0x29, d_altpc = 0x80. With the macro undefined -> f_pc = 0x80.
